imem_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the single-cycle CPU's instruction memory. It receives a length-prefixed, checksummed byte stream over a valid/ready interface and packs it into 32-bit little-endian instruction words. It writes those words sequentially into instruction memory and holds the CPU in reset until a complete, verified image is present. This lets the Fibonacci and other test programs be loaded at run time instead of through a compile-time memory init.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/byte_word_packer.sv | 29 ++
 rtl/imem_loader.sv | 125 ++++++++++++
 tb/tb_imem_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERR
  } state_t;

  localparam int unsigned LEN_BYTES = 2;
  localparam int unsigned CKSUM_W   = 8;

endpackage

// File: rtl/byte_word_packer.sv
// Packs a byte stream into 32-bit little-endian words; flags the 4th byte of each word.
module byte_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_complete,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  logic [31:0] shreg;

  // Shift right so the first byte of a word ends up in bits [7:0].
  assign word          = {byte_data, shreg[31:8]};
  assign word_complete = byte_en && (cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (byte_en) begin
      cnt   <= cnt + 2'd1;
      shreg <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory
// and holds the CPU in reset until a verified image is present.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned ADDR_W     = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  state_t             state;
  logic [15:0]        len;
  logic [CKSUM_W-1:0] acc;
  logic               xfer;
  logic               session_start;
  logic [15:0]        n_words;
  logic               word_complete;
  logic [31:0]        word;

  assign busy          = (state == LEN_LO) || (state == LEN_HI) ||
                         (state == DATA)   || (state == CHECK);
  assign byte_ready    = busy;
  assign xfer          = byte_valid && byte_ready;
  assign session_start = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign n_words       = {byte_data, len[7:0]};

  byte_word_packer u_packer (
    .clk           (clk),
    .rst           (rst),
    .clear         (session_start),
    .byte_en       (xfer && (state == DATA)),
    .byte_data     (byte_data),
    .word_complete (word_complete),
    .word          (word)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      len          <= '0;
      acc          <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= LEN_LO;
            words_loaded <= '0;
            acc          <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_rst      <= 1'b1;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            len[7:0] <= byte_data;
            state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len <= n_words;
            if (32'(n_words) > DEPTH_WORDS) begin
              state <= ERR;
              error <= 1'b1;
            end else if (n_words == 16'd0) begin
              state <= CHECK;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            acc <= acc ^ byte_data;
            if (word_complete) begin
              imem_we      <= 1'b1;
              imem_addr    <= words_loaded[ADDR_W-1:0];
              imem_wdata   <= word;
              words_loaded <= words_loaded + 16'd1;
              if (words_loaded + 16'd1 == len)
                state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (xfer) begin
            if (byte_data == acc) begin
              state   <= DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0]  nom [15] = '{8'h03, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00,
                            8'h13, 8'h01, 8'h10, 8'h00,
                            8'hb3, 8'h81, 8'h20, 8'h00, 8'h83};
  logic [31:0] exp_word [3] = '{32'h00000093, 32'h00100113, 32'h002081b3};

  int unsigned wr_cnt = 0;
  logic [7:0]  wr_addr [64];
  logic [31:0] wr_data [64];
  int unsigned base;

  imem_loader #(.DEPTH_WORDS(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every write strobe; each cycle of imem_we is one logged write.
  always @(negedge clk) begin
    if (imem_we === 1'b1 && wr_cnt < 64) begin
      wr_addr[wr_cnt] = imem_addr;
      wr_data[wr_cnt] = imem_wdata;
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_cpu_rst", cpu_rst, 1);
    chk("start_done_clr", done, 0);
    chk("start_err_clr", error, 0);
    chk("start_wl_clr", words_loaded, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, byte_ready, 0);
    chk({tag, "_we"}, imem_we, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_cpu_rst"}, cpu_rst, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_wl"}, words_loaded, 0);
  endtask

  task automatic check_writes(input string tag, input int unsigned b);
    chk({tag, "_wr_cnt"}, wr_cnt, b + 3);
    for (int unsigned i = 0; i < 3; i++) begin
      chk({tag, "_wr_addr"}, wr_addr[b + i], i);
      chk({tag, "_wr_data"}, wr_data[b + i], exp_word[i]);
    end
  endtask

  task automatic check_done(input string tag, input logic [15:0] wl);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_cpu_rst"}, cpu_rst, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, byte_ready, 0);
    chk({tag, "_wl"}, words_loaded, wl);
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;

    // Valid while idle is ignored.
    send(8'h55);
    idle(1);
    chk("idle_ignore_busy", busy, 0);

    // Nominal N=3 load, one byte per cycle.
    base = wr_cnt;
    pulse_start();
    for (int unsigned i = 0; i < 15; i++) begin
      send(nom[i]);
      if (i == 6) begin
        chk("w0_we", imem_we, 1);
        chk("w0_addr", imem_addr, 0);
        chk("w0_wdata", imem_wdata, 32'h00000093);
        chk("w0_wl", words_loaded, 1);
        chk("w0_cpu_rst", cpu_rst, 1);
      end
      if (i == 7) chk("w0_we_one_cycle", imem_we, 0);
    end
    idle(1);
    check_done("nom", 16'd3);
    check_writes("nom", base);
    idle(3);
    chk("nom_done_hold", done, 1);

    // Bad checksum.
    base = wr_cnt;
    pulse_start();
    for (int unsigned i = 0; i < 14; i++) send(nom[i]);
    send(8'h84);
    idle(1);
    chk("bad_error", error, 1);
    chk("bad_done", done, 0);
    chk("bad_cpu_rst", cpu_rst, 1);
    chk("bad_wl", words_loaded, 3);
    chk("bad_ready", byte_ready, 0);
    check_writes("bad", base);

    // Empty image.
    base = wr_cnt;
    pulse_start();
    send(8'h00);
    send(8'h00);
    idle(1);
    chk("empty_in_check", busy, 1);
    chk("empty_not_done", done, 0);
    send(8'h00);
    idle(1);
    check_done("empty", 16'd0);
    chk("empty_no_we", wr_cnt, base);

    // Length overflow N=257.
    base = wr_cnt;
    pulse_start();
    send(8'h01);
    send(8'h01);
    idle(1);
    chk("ovf_error", error, 1);
    chk("ovf_ready", byte_ready, 0);
    chk("ovf_cpu_rst", cpu_rst, 1);
    chk("ovf_done", done, 0);
    idle(3);
    chk("ovf_no_we", wr_cnt, base);

    // Stalled stream, with a start pulse mid-session that must be ignored.
    base = wr_cnt;
    pulse_start();
    for (int unsigned i = 0; i < 15; i++) begin
      send(nom[i]);
      if (i == 7) begin
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end else begin
        idle(2);
      end
    end
    check_done("stall", 16'd3);
    check_writes("stall", base);

    // Reset in the middle of DATA, then a clean reload.
    pulse_start();
    for (int unsigned i = 0; i < 7; i++) send(nom[i]);
    @(negedge clk);
    byte_valid = 1'b0;
    rst        = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    rst  = 1'b1;
    base = wr_cnt;
    pulse_start();
    for (int unsigned i = 0; i < 15; i++) send(nom[i]);
    idle(1);
    check_done("reload", 16'd3);
    check_writes("reload", base);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
